imm_gen_pipe: RTL and testbench



---
 rtl/imm_gen_pipe_if.sv | 28 ++
 rtl/imm_gen_pipe.sv | 149 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       imm_src;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_ext;
    logic [2:0]       imm_fmt;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    // Environment side: produces instructions, consumes immediates.
    modport master (
        output in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, imm_ext, imm_fmt, illegal, illegal_cnt
    );

    // Generator side.
    modport slave (
        input  in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, imm_ext, imm_fmt, illegal, illegal_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RISC-V immediate generator with 2-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 0,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_S  = 3'd1;
    localparam logic [2:0] FMT_B  = 3'd2;
    localparam logic [2:0] FMT_J  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_Z  = 3'd5;
    localparam logic [2:0] FMT_SH = 3'd6;
    localparam logic [2:0] FMT_R  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      ins;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [2:0]       fmt;
    logic [63:0]      wide;
    logic [XLEN-1:0]  new_imm;
    logic             new_ill;
    logic             unused_wide;

    logic             p_valid;
    logic [XLEN-1:0]  p_imm;
    logic [2:0]       p_fmt;
    logic             p_ill;
    logic             s_valid;
    logic [XLEN-1:0]  s_imm;
    logic [2:0]       s_fmt;
    logic             s_ill;
    logic             ready_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             stall;

    assign ins    = bus.instr;
    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];

    // Resolve the immediate format: external select or own opcode decode.
    always_comb begin
        fmt = FMT_R;
        if (AUTO_DECODE == 0) begin
            fmt = bus.imm_src;
        end else begin
            case (opcode)
                7'b0000011, 7'b1100111: fmt = FMT_I;
                7'b0010011:             fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
                7'b0100011:             fmt = FMT_S;
                7'b1100011:             fmt = FMT_B;
                7'b1101111:             fmt = FMT_J;
                7'b0110111, 7'b0010111: fmt = FMT_U;
                7'b1110011:             fmt = funct3[2] ? FMT_Z : FMT_I;
                default:                fmt = FMT_R;
            endcase
        end
    end

    // Build the immediate at 64 bits and keep the low XLEN; sign fill comes from instr[31].
    always_comb begin
        wide = '0;
        case (fmt)
            FMT_I:   wide = {{52{ins[31]}}, ins[31:20]};
            FMT_S:   wide = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   wide = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_J:   wide = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            FMT_U:   wide = {{32{ins[31]}}, ins[31:12], 12'b0};
            FMT_Z:   wide = {59'b0, ins[19:15]};
            FMT_SH:  wide = (XLEN == 64) ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
            default: wide = '0;
        endcase
    end

    assign new_imm     = wide[XLEN-1:0];
    assign new_ill     = (fmt == FMT_R);
    assign unused_wide = ^wide;

    assign accept = bus.in_valid & ready_q;
    assign stall  = p_valid & ~bus.out_ready;

    // Primary/skid buffer: skid fills only while primary is stalled and refills primary when it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_imm   <= '0;
            p_fmt   <= 3'd0;
            p_ill   <= 1'b0;
            s_valid <= 1'b0;
            s_imm   <= '0;
            s_fmt   <= 3'd0;
            s_ill   <= 1'b0;
            ready_q <= 1'b0;
        end else if (flush) begin
            p_valid <= 1'b0;
            s_valid <= 1'b0;
            ready_q <= 1'b1;
        end else if (!stall) begin
            ready_q <= 1'b1;
            if (s_valid) begin
                p_valid <= 1'b1;
                p_imm   <= s_imm;
                p_fmt   <= s_fmt;
                p_ill   <= s_ill;
                s_valid <= 1'b0;
            end else if (accept) begin
                p_valid <= 1'b1;
                p_imm   <= new_imm;
                p_fmt   <= fmt;
                p_ill   <= new_ill;
            end else begin
                p_valid <= 1'b0;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_imm   <= new_imm;
            s_fmt   <= fmt;
            s_ill   <= new_ill;
            ready_q <= 1'b0;
        end else begin
            ready_q <= ~s_valid;
        end
    end

    // Saturating count of accepted illegal formats; flush neither counts nor clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && !flush && new_ill && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.out_valid   = p_valid;
    assign bus.imm_ext     = p_imm;
    assign bus.imm_fmt     = p_fmt;
    assign bus.illegal     = p_ill;
    assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - table-driven scoreboard bench for imm_gen_pipe
module tb_imm_gen_pipe;
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush32;
    logic flush64;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .CNT_W(2))  b64 ();

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .CNT_W(16)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(b32.slave)
    );
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .CNT_W(2)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .bus(b64.slave)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t q32[$];
    exp_t q64[$];
    vec_t t32[10];
    vec_t t64[12];
    logic [31:0] bp_instr[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !flush32 && b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb32_unexpected actual=%h required=none", b32.imm_ext);
            end else begin
                e = q32.pop_front();
                check("sb32_imm", 64'(b32.imm_ext), e.imm);
                check("sb32_fmt", 64'(b32.imm_fmt), 64'(e.fmt));
                check("sb32_ill", 64'(b32.illegal), 64'(e.ill));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !flush64 && b64.out_valid && b64.out_ready) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb64_unexpected actual=%h required=none", b64.imm_ext);
            end else begin
                e = q64.pop_front();
                check("sb64_imm", b64.imm_ext, e.imm);
                check("sb64_fmt", 64'(b64.imm_fmt), 64'(e.fmt));
                check("sb64_ill", 64'(b64.illegal), 64'(e.ill));
            end
        end
    end

    task automatic send32(input vec_t v);
        bit done = 0;
        exp_t e;
        e.imm = v.imm; e.fmt = v.fmt; e.ill = v.ill;
        b32.in_valid = 1'b1; b32.imm_src = v.src; b32.instr = v.instr;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (b32.in_ready) begin
                q32.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        b32.in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send32_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic send64(input vec_t v);
        bit done = 0;
        exp_t e;
        e.imm = v.imm; e.fmt = v.fmt; e.ill = v.ill;
        b64.in_valid = 1'b1; b64.imm_src = v.src; b64.instr = v.instr;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (b64.in_ready) begin
                q64.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        b64.in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send64_timeout actual=no_accept required=accept");
        end
    endtask

    initial begin
        int   idx;
        vec_t v;
        exp_t e;

        t32[0] = '{3'd0, 32'hFFF00093, 64'hFFFF_FFFF, 3'd0, 1'b0};
        t32[1] = '{3'd1, 32'hFE20AE23, 64'hFFFF_FFFC, 3'd1, 1'b0};
        t32[2] = '{3'd2, 32'hFE000CE3, 64'hFFFF_FFF8, 3'd2, 1'b0};
        t32[3] = '{3'd3, 32'h001000EF, 64'h0000_0800, 3'd3, 1'b0};
        t32[4] = '{3'd4, 32'h123452B7, 64'h1234_5000, 3'd4, 1'b0};
        t32[5] = '{3'd5, 32'hFFFFFFFF, 64'h0000_001F, 3'd5, 1'b0};
        t32[6] = '{3'd6, 32'hFFFFFFFF, 64'h0000_001F, 3'd6, 1'b0};
        t32[7] = '{3'd7, 32'h12345678, 64'h0000_0000, 3'd7, 1'b1};
        t32[8] = '{3'd0, 32'h7FF00013, 64'h0000_07FF, 3'd0, 1'b0};
        t32[9] = '{3'd2, 32'h00000463, 64'h0000_0008, 3'd2, 1'b0};

        t64[0]  = '{3'd7, 32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
        t64[1]  = '{3'd7, 32'h00001017, 64'h0000_0000_0000_1000, 3'd4, 1'b0};
        t64[2]  = '{3'd7, 32'h03F01293, 64'h0000_0000_0000_003F, 3'd6, 1'b0};
        t64[3]  = '{3'd7, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0};
        t64[4]  = '{3'd7, 32'h000FD073, 64'h0000_0000_0000_001F, 3'd5, 1'b0};
        t64[5]  = '{3'd7, 32'h00109073, 64'h0000_0000_0000_0001, 3'd0, 1'b0};
        t64[6]  = '{3'd7, 32'hFE20AE23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0};
        t64[7]  = '{3'd7, 32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0};
        t64[8]  = '{3'd7, 32'h001000EF, 64'h0000_0000_0000_0800, 3'd3, 1'b0};
        t64[9]  = '{3'd7, 32'h00402083, 64'h0000_0000_0000_0004, 3'd0, 1'b0};
        t64[10] = '{3'd7, 32'h40505013, 64'h0000_0000_0000_0005, 3'd6, 1'b0};
        t64[11] = '{3'd7, 32'h00000000, 64'h0000_0000_0000_0000, 3'd7, 1'b1};

        bp_instr[0] = 32'h00100093;
        bp_instr[1] = 32'h00200093;
        bp_instr[2] = 32'h00300093;
        bp_instr[3] = 32'h00400093;

        rst_n = 1'b0; flush32 = 1'b0; flush64 = 1'b0;
        b32.in_valid = 1'b0; b32.instr = '0; b32.imm_src = '0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.instr = '0; b64.imm_src = '0; b64.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid32", 64'(b32.out_valid), 64'd0);
        check("rst_imm32", 64'(b32.imm_ext), 64'd0);
        check("rst_fmt32", 64'(b32.imm_fmt), 64'd0);
        check("rst_ill32", 64'(b32.illegal), 64'd0);
        check("rst_cnt32", 64'(b32.illegal_cnt), 64'd0);
        check("rst_out_valid64", 64'(b64.out_valid), 64'd0);
        check("rst_imm64", b64.imm_ext, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready32", 64'(b32.in_ready), 64'd1);
        check("rst_in_ready64", 64'(b64.in_ready), 64'd1);

        // Table pass, XLEN=32: each output valid exactly one edge after its accept.
        check("idle_out_valid32", 64'(b32.out_valid), 64'd0);
        for (int i = 0; i < 10; i++) begin
            send32(t32[i]);
            check("lat32", 64'(b32.out_valid), 64'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain32", 64'(q32.size()), 64'd0);
        check("cnt32_after_table", 64'(b32.illegal_cnt), 64'd1);

        // Saturating counter, CNT_W=2: 1,2,3,3,3.
        for (int i = 0; i < 5; i++) begin
            v = '{3'd0, 32'h00000000, 64'd0, 3'd7, 1'b1};
            send64(v);
            check("cnt64_seq", 64'(b64.illegal_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
        end

        // Table pass, XLEN=64 with opcode decode; imm_src held at 111 to show it is ignored.
        for (int i = 0; i < 12; i++) begin
            send64(t64[i]);
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain64", 64'(q64.size()), 64'd0);

        // Backpressure: A,B accepted during a 3-cycle stall, then A..D drain back to back.
        idx = 0;
        b32.in_valid = 1'b1; b32.imm_src = 3'd0; b32.instr = bp_instr[0];
        for (int k = 0; k < 9; k++) begin
            b32.out_ready = (k >= 3);
            @(negedge clk);
            if (k >= 3 && k <= 6) check("bp_no_gap", 64'(b32.out_valid), 64'd1);
            if (k == 7) check("bp_empty", 64'(b32.out_valid), 64'd0);
            if (k == 2) begin
                check("bp_accepted", 64'(idx), 64'd2);
                check("bp_in_ready", 64'(b32.in_ready), 64'd0);
                check("bp_hold_imm", 64'(b32.imm_ext), 64'd1);
            end
            if (b32.in_valid && b32.in_ready) begin
                e.imm = 64'(idx + 1); e.fmt = 3'd0; e.ill = 1'b0;
                q32.push_back(e);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) b32.instr = bp_instr[idx];
            else b32.in_valid = 1'b0;
        end
        check("bp_total", 64'(idx), 64'd4);
        check("bp_drained", 64'(q32.size()), 64'd0);

        // Flush with both entries full and an input presented.
        b32.out_ready = 1'b0;
        v = '{3'd0, 32'h00500093, 64'd5, 3'd0, 1'b0};
        send32(v);
        v = '{3'd0, 32'h00600093, 64'd6, 3'd0, 1'b0};
        send32(v);
        check("fl_full_in_ready", 64'(b32.in_ready), 64'd0);
        flush32 = 1'b1;
        b32.in_valid = 1'b1; b32.imm_src = 3'd0; b32.instr = 32'h7FF00093;
        @(posedge clk); #1;
        flush32 = 1'b0;
        b32.in_valid = 1'b0;
        q32.delete();
        check("fl_out_valid", 64'(b32.out_valid), 64'd0);
        check("fl_in_ready", 64'(b32.in_ready), 64'd1);
        b32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fl_nothing_emerges", 64'(b32.out_valid), 64'd0);

        // Flush while ready: illegal input is dropped and not counted.
        flush32 = 1'b1;
        b32.in_valid = 1'b1; b32.imm_src = 3'd7; b32.instr = 32'h0;
        @(posedge clk); #1;
        flush32 = 1'b0;
        b32.in_valid = 1'b0;
        check("fl_cnt_kept", 64'(b32.illegal_cnt), 64'd1);
        check("fl_drop_valid", 64'(b32.out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("fl_drop_late", 64'(b32.out_valid), 64'd0);

        // Asynchronous reset between edges with a stalled entry held.
        b64.out_ready = 1'b0;
        send64(t64[0]);
        check("ar_held_valid", 64'(b64.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(b64.out_valid), 64'd0);
        check("ar_imm", b64.imm_ext, 64'd0);
        check("ar_fmt", 64'(b64.imm_fmt), 64'd0);
        check("ar_cnt64", 64'(b64.illegal_cnt), 64'd0);
        check("ar_cnt32", 64'(b32.illegal_cnt), 64'd0);
        q64.delete();
        q32.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        b64.out_ready = 1'b1;
        @(posedge clk); #1;
        check("ar_in_ready", 64'(b64.in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
